fish_gate_counter: RTL and testbench

FISH_GATE_COUNTER -- requirements
Module: fish_gate_counter

---
 rtl/fish_gate_pkg.sv | 26 ++
 rtl/fish_debounce.sv | 47 ++++
 rtl/fish_gate_counter.sv | 151 +++++++++++++++
 tb/tb_fish_gate_counter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fish_gate_pkg.sv
// Shared types and widths for the fish gate passage counter.
package fish_gate_pkg;

    localparam int COUNT_W = 16;
    localparam int AGE_W   = 24;
    localparam int DEB_W   = 16;

    // Passage FSM states. The inbound path is A1 -> AB_IN -> B2 and the
    // outbound path mirrors it as B1 -> AB_OUT -> A2.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_A1     = 3'd1,
        ST_AB_IN  = 3'd2,
        ST_B2     = 3'd3,
        ST_B1     = 3'd4,
        ST_AB_OUT = 3'd5,
        ST_A2     = 3'd6,
        ST_ABORT  = 3'd7
    } gate_state_t;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fish_debounce.sv
// One photobeam input: 2-flop synchronizer followed by a stability filter.
// The filtered output only follows the synchronized input once they have
// disagreed for DEBOUNCE_CYCLES consecutive cycles.
module fish_debounce
    import fish_gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filtered
);

    localparam logic [DEB_W-1:0] STABLE_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [DEB_W-1:0] stable_count;

    // Bring the asynchronous beam into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filtered     <= 1'b0;
            stable_count <= '0;
        end else if (sync_2 == filtered) begin
            stable_count <= '0;
        end else if (stable_count == STABLE_LAST) begin
            filtered     <= sync_2;
            stable_count <= '0;
        end else begin
            stable_count <= stable_count + 1'b1;
        end
    end

endmodule

// File: rtl/fish_gate_counter.sv
// Two-beam fish gate: debounces both sensors, tracks each passage with an
// FSM, and keeps saturating inbound/outbound counts for the PIO.
module fish_gate_counter
    import fish_gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES  = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sensor_a,
    input  logic        sensor_b,
    input  logic        clear,
    output logic [31:0] count_out,
    output logic        pass_in_pulse,
    output logic        pass_out_pulse,
    output logic        abort_pulse
);

    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);

    logic               a_filt;
    logic               b_filt;
    logic [1:0]         pair;
    gate_state_t        state;
    gate_state_t        next_state;
    logic [AGE_W-1:0]   age;
    logic               timed_out;
    logic               in_done;
    logic               out_done;
    logic               abort_entry;
    logic [COUNT_W-1:0] in_count;
    logic [COUNT_W-1:0] out_count;

    fish_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (sensor_a),
        .filtered (a_filt)
    );

    fish_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (sensor_b),
        .filtered (b_filt)
    );

    assign pair      = {a_filt, b_filt};
    assign timed_out = (state != ST_IDLE) && (state != ST_ABORT) && (age == AGE_LAST);
    assign count_out = {out_count, in_count};

    // Next-state decode on the filtered pair; a stuck passage is forced to ABORT.
    always_comb begin
        next_state  = state;
        in_done     = 1'b0;
        out_done    = 1'b0;
        abort_entry = 1'b0;
        case (state)
            ST_IDLE:   case (pair)
                           2'b10:   next_state = ST_A1;
                           2'b01:   next_state = ST_B1;
                           2'b11:   next_state = ST_ABORT;
                           default: next_state = ST_IDLE;
                       endcase
            ST_A1:     case (pair)
                           2'b10:   next_state = ST_A1;
                           2'b11:   next_state = ST_AB_IN;
                           2'b00:   next_state = ST_IDLE;
                           default: next_state = ST_ABORT;
                       endcase
            ST_AB_IN:  case (pair)
                           2'b11:   next_state = ST_AB_IN;
                           2'b01:   next_state = ST_B2;
                           2'b10:   next_state = ST_A1;
                           default: next_state = ST_ABORT;
                       endcase
            ST_B2:     case (pair)
                           2'b01:   next_state = ST_B2;
                           2'b00:   next_state = ST_IDLE;
                           2'b11:   next_state = ST_AB_IN;
                           default: next_state = ST_ABORT;
                       endcase
            ST_B1:     case (pair)
                           2'b01:   next_state = ST_B1;
                           2'b11:   next_state = ST_AB_OUT;
                           2'b00:   next_state = ST_IDLE;
                           default: next_state = ST_ABORT;
                       endcase
            ST_AB_OUT: case (pair)
                           2'b11:   next_state = ST_AB_OUT;
                           2'b10:   next_state = ST_A2;
                           2'b01:   next_state = ST_B1;
                           default: next_state = ST_ABORT;
                       endcase
            ST_A2:     case (pair)
                           2'b10:   next_state = ST_A2;
                           2'b00:   next_state = ST_IDLE;
                           2'b11:   next_state = ST_AB_OUT;
                           default: next_state = ST_ABORT;
                       endcase
            default:   next_state = (pair == 2'b00) ? ST_IDLE : ST_ABORT;
        endcase
        if (timed_out) begin
            next_state = ST_ABORT;
        end
        in_done     = (state == ST_B2) && (next_state == ST_IDLE);
        out_done    = (state == ST_A2) && (next_state == ST_IDLE);
        abort_entry = (state != ST_ABORT) && (next_state == ST_ABORT);
    end

    // State register, state-age counter and registered event strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            age            <= '0;
            pass_in_pulse  <= 1'b0;
            pass_out_pulse <= 1'b0;
            abort_pulse    <= 1'b0;
        end else begin
            state          <= next_state;
            if (next_state != state) begin
                age <= '0;
            end else if (age != '1) begin
                age <= age + 1'b1;
            end
            pass_in_pulse  <= in_done;
            pass_out_pulse <= out_done;
            abort_pulse    <= abort_entry;
        end
    end

    // Saturating passage counts; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_count  <= '0;
            out_count <= '0;
        end else if (clear) begin
            in_count  <= '0;
            out_count <= '0;
        end else begin
            if (pass_in_pulse) begin
                in_count <= sat_inc(in_count);
            end
            if (pass_out_pulse) begin
                out_count <= sat_inc(out_count);
            end
        end
    end

endmodule

// File: tb/tb_fish_gate_counter.sv
// Directed and randomized bench for fish_gate_counter. Passages are scripted
// as sequences of beam patterns; the reference model only knows what each
// script should amount to (inbound, outbound, nothing, or an abort).
module tb_fish_gate_counter;
    import fish_gate_pkg::*;

    localparam int DEB = 4;
    localparam int TO  = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sensor_a = 1'b0;
    logic        sensor_b = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] count_out;
    logic        pass_in_pulse;
    logic        pass_out_pulse;
    logic        abort_pulse;

    int checks = 0;
    int errors = 0;

    // Pulses observed on the outputs.
    int   n_in = 0;
    int   n_out = 0;
    int   n_abort = 0;
    logic prev_any = 1'b0;

    // Reference model.
    int exp_in = 0;
    int exp_out = 0;
    int exp_abort = 0;
    int model_in = 0;
    int model_out = 0;

    always #5 clk = ~clk;

    fish_gate_counter #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sensor_a       (sensor_a),
        .sensor_b       (sensor_b),
        .clear          (clear),
        .count_out      (count_out),
        .pass_in_pulse  (pass_in_pulse),
        .pass_out_pulse (pass_out_pulse),
        .abort_pulse    (abort_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word();
        return {model_out[15:0], model_in[15:0]};
    endfunction

    task automatic model_pass_in();
        exp_in++;
        model_in = (model_in < 65535) ? model_in + 1 : 65535;
    endtask

    task automatic model_pass_out();
        exp_out++;
        model_out = (model_out < 65535) ? model_out + 1 : 65535;
    endtask

    // Pulse monitor: counts strobes and checks spacing/exclusivity.
    always @(negedge clk) begin
        if (pass_in_pulse === 1'b1)  n_in++;
        if (pass_out_pulse === 1'b1) n_out++;
        if (abort_pulse === 1'b1)    n_abort++;
        if (reset_n && (pass_in_pulse || pass_out_pulse || abort_pulse)) begin
            chk("pulse_spacing", 32'(prev_any), 32'd0);
            chk("pulse_onehot", 32'(pass_in_pulse) + 32'(pass_out_pulse) + 32'(abort_pulse), 32'd1);
        end
        prev_any = pass_in_pulse | pass_out_pulse | abort_pulse;
    end

    // Apply a beam pattern at a falling edge and hold it.
    task automatic drive(input logic a, input logic b, input int hold);
        sensor_a = a;
        sensor_b = b;
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_in  = 0;
        model_out = 0;
    endtask

    task automatic check_totals(input string tag);
        chk({tag, "_count"}, count_out, model_word());
        chk({tag, "_in_pulses"}, 32'(n_in), 32'(exp_in));
        chk({tag, "_out_pulses"}, 32'(n_out), 32'(exp_out));
        chk({tag, "_abort_pulses"}, 32'(n_abort), 32'(exp_abort));
    endtask

    // One scripted passage with random hold times and optional short glitches.
    task automatic run_script(input int kind);
        logic [1:0] pats [6];
        int len;
        len = 0;
        case (kind)
            0: begin pats[0] = 2'b10; pats[1] = 2'b11; pats[2] = 2'b01; pats[3] = 2'b00; len = 4; end
            1: begin pats[0] = 2'b01; pats[1] = 2'b11; pats[2] = 2'b10; pats[3] = 2'b00; len = 4; end
            2: begin pats[0] = 2'b10; pats[1] = 2'b11; pats[2] = 2'b10; pats[3] = 2'b00; len = 4; end
            3: begin pats[0] = 2'b10; pats[1] = 2'b11; pats[2] = 2'b01; pats[3] = 2'b11;
                     pats[4] = 2'b01; pats[5] = 2'b00; len = 6; end
            4: begin pats[0] = 2'b10; pats[1] = 2'b01; pats[2] = 2'b00; len = 3; end
            default: begin pats[0] = 2'b01; pats[1] = 2'b11; pats[2] = 2'b01; pats[3] = 2'b00; len = 4; end
        endcase
        for (int i = 0; i < len; i++) begin
            drive(pats[i][1], pats[i][0], int'($urandom_range(8, 12)));
            if ($urandom_range(0, 3) == 0) begin
                sensor_a = ~sensor_a;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                sensor_a = pats[i][1];
                repeat (8) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        case (kind)
            0, 3:    model_pass_in();
            1:       model_pass_out();
            4:       exp_abort++;
            default: ;
        endcase
        check_totals($sformatf("script%0d", kind));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        int  kind;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_count", count_out, 32'h0);
        chk("reset_pulses", {29'b0, pass_in_pulse, pass_out_pulse, abort_pulse}, 32'h0);
        chk("reset_state", 32'(dut.state), 32'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clk);

        // Inbound passage, with the count landing one cycle after the strobe.
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pass_in_pulse) begin
                found = 1'b1;
                break;
            end
        end
        chk("in_pulse_seen", 32'(found), 32'd1);
        chk("in_count_before", count_out, 32'h0);
        @(negedge clk);
        chk("in_count_after", count_out, 32'h0000_0001);
        repeat (8) @(negedge clk);
        model_pass_in();
        check_totals("inbound");

        // Mirror passage from zeroed counts.
        do_clear();
        chk("clear_count", count_out, 32'h0);
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        model_pass_out();
        chk("outbound_word", count_out, 32'h0001_0000);
        check_totals("outbound");

        // A 2-cycle glitch on sensor_a must not move the FSM.
        drive(1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 10);
        chk("glitch_state", 32'(dut.state), 32'(ST_IDLE));
        check_totals("glitch");

        // Stuck beam: abort after TO cycles in A1, exit only once a is released.
        sensor_a = 1'b1;
        n = 0;
        found = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (abort_pulse) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_seen", 32'(found), 32'd1);
        chk("abort_latency", 32'(n), 32'(2 + DEB + 1 + TO));
        exp_abort++;
        repeat (150 - n) @(negedge clk);
        chk("abort_hold_state", 32'(dut.state), 32'(ST_ABORT));
        sensor_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_before_debounce", 32'(dut.state), 32'(ST_ABORT));
        repeat (4) @(negedge clk);
        chk("abort_exit_state", 32'(dut.state), 32'(ST_IDLE));
        check_totals("abort");

        // Randomized scripted passages.
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 5));
            run_script(kind);
        end

        // Clear in the same cycle as a pass strobe.
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pass_in_pulse) begin
                found = 1'b1;
                break;
            end
        end
        chk("clear_race_pulse_seen", 32'(found), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_in++;
        model_in  = 0;
        model_out = 0;
        chk("clear_race_word", count_out, 32'h0);
        repeat (6) @(negedge clk);
        check_totals("clear_race");

        // Saturation: preload just below full, then two more inbound passages.
        force dut.in_count = 16'hFFFE;
        @(negedge clk);
        release dut.in_count;
        model_in = 65534;
        @(negedge clk);
        chk("preload_word", count_out, model_word());
        run_script(0);
        chk("sat_first", count_out, 32'h0000_FFFF);
        run_script(0);
        chk("sat_hold", count_out, 32'h0000_FFFF);

        // Reset in the middle of a passage.
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        chk("pre_reset_state", 32'(dut.state), 32'(ST_AB_IN));
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_count", count_out, 32'h0);
        chk("reset_mid_pulses", {29'b0, pass_in_pulse, pass_out_pulse, abort_pulse}, 32'h0);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        model_in  = 0;
        model_out = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        chk("post_reset_state", 32'(dut.state), 32'(ST_IDLE));
        check_totals("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
